// File: rtl/switch_allocator.sv
// Packet-level switch allocator: per-output round-robin arbitration with a packet lock held until the tail transfers.
// A request in cycle n locks in n+1; transfers are gated by in_valid[owner] & out_ready[o], and a bubble or stall keeps the lock.
module switch_allocator #(
  parameter int NPORTS = 5,
  parameter int DIR_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NPORTS-1:0]         in_valid,
  input  logic [NPORTS-1:0]         in_tail,
  input  logic [DIR_W-1:0]          e_req,
  input  logic [DIR_W-1:0]          w_req,
  input  logic [DIR_W-1:0]          n_req,
  input  logic [DIR_W-1:0]          s_req,
  input  logic [DIR_W-1:0]          j_req,
  input  logic [NPORTS-1:0]         out_ready,
  output logic [NPORTS-1:0]         in_gnt,
  output logic [NPORTS-1:0]         out_valid,
  output logic [NPORTS*DIR_W-1:0]   xbar_sel,
  output logic [NPORTS-1:0]         out_busy,
  output logic                      err_dir
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state_q [NPORTS];
  state_t             state_d [NPORTS];
  logic [DIR_W-1:0]   owner_q [NPORTS];
  logic [DIR_W-1:0]   owner_d [NPORTS];
  logic [DIR_W-1:0]   ptr_q   [NPORTS];
  logic [DIR_W-1:0]   ptr_d   [NPORTS];
  logic [DIR_W-1:0]   code    [NPORTS];
  logic [NPORTS-1:0]  req     [NPORTS];
  logic [NPORTS-1:0]  owned;
  logic [NPORTS-1:0]  bad;
  logic [NPORTS-1:0]  xfer;
  logic [DIR_W:0]     sum;
  logic [DIR_W-1:0]   cand;
  logic               found;
  logic               err_q;

  assign code[0] = e_req;
  assign code[1] = w_req;
  assign code[2] = n_req;
  assign code[3] = s_req;
  assign code[4] = j_req;

  // An input already locked to some output may not request another one.
  always_comb begin
    owned = '0;
    bad   = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (state_q[o] == LOCKED) owned[owner_q[o]] = 1'b1;
    end
    for (int i = 0; i < NPORTS; i++) begin
      bad[i] = in_valid[i] & (code[i] >= DIR_W'(NPORTS));
    end
    for (int o = 0; o < NPORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        req[o][i] = in_valid[i] & (code[i] == DIR_W'(o)) & ~owned[i];
      end
    end
  end

  always_comb begin
    sum   = '0;
    cand  = '0;
    found = 1'b0;
    for (int o = 0; o < NPORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      xfer[o]    = 1'b0;
      if (state_q[o] == IDLE) begin
        found = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
          sum = {1'b0, ptr_q[o]} + (DIR_W+1)'(k);
          if (sum >= (DIR_W+1)'(NPORTS)) sum = sum - (DIR_W+1)'(NPORTS);
          cand = sum[DIR_W-1:0];
          if (!found && req[o][cand]) begin
            found      = 1'b1;
            owner_d[o] = cand;
            state_d[o] = LOCKED;
          end
        end
      end else begin
        xfer[o] = in_valid[owner_q[o]] & out_ready[o];
        if (xfer[o] && in_tail[owner_q[o]]) begin
          state_d[o] = IDLE;
          ptr_d[o]   = (owner_q[o] == DIR_W'(NPORTS-1)) ? '0 : owner_q[o] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
      err_q <= err_q | (|bad);
    end
  end

  always_comb begin
    in_gnt   = '0;
    out_busy = '0;
    xbar_sel = '1;
    for (int o = 0; o < NPORTS; o++) begin
      out_busy[o] = (state_q[o] == LOCKED);
      if (state_q[o] == LOCKED) xbar_sel[o*DIR_W +: DIR_W] = owner_q[o];
      for (int i = 0; i < NPORTS; i++) begin
        if (xfer[o] && owner_q[o] == DIR_W'(i)) in_gnt[i] = 1'b1;
      end
    end
  end

  assign out_valid = xfer;
  assign err_dir   = err_q;

endmodule
